uart_mem_dump: RTL and testbench

UART memory readback engine: the transmit-side counterpart of the UART boot programmer that loads instruction and data memory. On a start pulse it reads a range of 32-bit words through a synchronous memory read port and serializes each word over an 8N1 UART line, least-significant byte first. Sits beside the programmer at the CPU top and shares its 15-bit word-address space (bit 14 selects data memory over instruction memory).

---
 rtl/uart_mem_dump.sv | 110 +++++++++++
 tb/tb_uart_mem_dump.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_dump.sv
// uart_mem_dump: reads a word range through a sync read port and sends each word LSB byte first over 8N1 UART
module uart_mem_dump #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADR_W        = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [ADR_W-1:0] base_adr_i,
    input  logic [ADR_W-1:0] word_cnt_i,
    output logic             mem_rd_o,
    output logic [ADR_W-1:0] mem_adr_o,
    input  logic [31:0]      mem_dat_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, DONE} state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d, rem_q, rem_d, mem_adr_q, mem_adr_d;
    logic [31:0]      sh_q, sh_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic             tx_q, tx_d, rd_q, busy_q, done_q, last;

    assign last      = baud_q == BW'(CLKS_PER_BIT - 1);
    assign mem_rd_o  = rd_q;
    assign mem_adr_o = mem_adr_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

    // Next state plus next output values, so every output leaves a flop
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: if (start_i) begin
                adr_d   = base_adr_i;
                rem_d   = word_cnt_i;
                state_d = word_cnt_i == '0 ? DONE : READ;
            end
            READ: state_d = LATCH;
            LATCH: begin
                sh_d    = mem_dat_i;
                baud_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
                adr_d   = adr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = SEND;
            end
            SEND: begin
                baud_d = last ? '0 : baud_q + 1'b1;
                if (last) begin
                    bit_d = bit_q == 4'd9 ? 4'd0 : bit_q + 1'b1;
                    if (bit_q >= 4'd1 && bit_q <= 4'd8) sh_d = sh_q >> 1;
                    if (bit_q == 4'd9) begin
                        byte_d = byte_q + 1'b1;
                        if (byte_q == 2'd3) state_d = rem_q != '0 ? READ : DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_adr_d = state_d == READ ? adr_d : mem_adr_q;
        tx_d      = state_d != SEND || (bit_d != 4'd0 && (bit_d == 4'd9 || sh_d[0]));
    end

    // State, datapath and registered outputs; async active-low reset abandons any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            rem_q     <= '0;
            sh_q      <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            mem_adr_q <= '0;
            tx_q      <= 1'b1;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            rem_q     <= rem_d;
            sh_q      <= sh_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            mem_adr_q <= mem_adr_d;
            tx_q      <= tx_d;
            rd_q      <= state_d == READ;
            busy_q    <= state_d inside {READ, LATCH, SEND};
            done_q    <= state_d == DONE;
        end
    end
endmodule

// File: tb/tb_uart_mem_dump.sv
// tb_uart_mem_dump: directed checks of uart_mem_dump with a BRAM model and a UART frame decoder
module tb_uart_mem_dump;
    localparam int C  = 4;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_adr_i = '0;
    logic [AW-1:0] word_cnt_i = '0;
    logic          mem_rd_o;
    logic [AW-1:0] mem_adr_o;
    logic [31:0]   mem_dat_i;
    logic          tx_o, busy_o, done_o;

    uart_mem_dump #(.CLKS_PER_BIT(C), .ADR_W(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_adr_i(base_adr_i),
        .word_cnt_i(word_cnt_i), .mem_rd_o(mem_rd_o), .mem_adr_o(mem_adr_o),
        .mem_dat_i(mem_dat_i), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [int];
    int          cyc = 0;
    int          rd_adr [$];
    int          fs_q [$];
    logic [8:0]  rx_q [$];
    int          n_busy = 0, n_done = 0, n_txlow = 0;
    logic        rx_act = 1'b0;
    int          rx_cnt = 0;
    logic [7:0]  rx_sh = '0;
    int          n_chk = 0, n_fail = 0;

    // Synchronous-read memory model and read-address log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_o) begin
            mem_dat_i <= mem.exists(int'(mem_adr_o)) ? mem[int'(mem_adr_o)] : 32'hBADC0DE5;
            rd_adr.push_back(int'(mem_adr_o));
        end
    end

    // Output activity counters
    always @(negedge clk) begin
        if (busy_o) n_busy <= n_busy + 1;
        if (done_o) n_done <= n_done + 1;
        if (!tx_o) n_txlow <= n_txlow + 1;
    end

    // UART decoder: samples mid-bit, logs {stop, data} and the cycle each frame starts
    always @(negedge clk) begin
        if (!rst) rx_act <= 1'b0;
        else if (!rx_act) begin
            if (!tx_o) begin
                rx_act <= 1'b1;
                rx_cnt <= 0;
                fs_q.push_back(cyc);
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if ((rx_cnt + 1) % C == C / 2 && rx_cnt + 1 < 9 * C) rx_sh <= {tx_o, rx_sh[7:1]};
            if (rx_cnt + 1 == 9 * C + C / 2) begin
                rx_q.push_back({tx_o, rx_sh});
                rx_act <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx"}, tx_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_rd"}, mem_rd_o, 0);
        chk({tag, "_adr"}, mem_adr_o, 0);
    endtask

    task automatic run_dump(input logic [AW-1:0] base, input logic [AW-1:0] cnt, input int inj);
        int          b0, r0, f0, s0, d0, t0, c0, lim, a;
        logic        seen;
        logic [7:0]  eb;
        b0 = n_busy; r0 = rd_adr.size(); f0 = rx_q.size(); s0 = fs_q.size();
        d0 = n_done; t0 = n_txlow;
        lim = int'(cnt) * (2 + 40 * C) + 10;
        @(negedge clk);
        base_adr_i = base; word_cnt_i = cnt; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        c0 = cyc;
        if (cnt == 0) begin
            chk("zero_done_next", done_o, 1);
            chk("zero_no_rd", mem_rd_o, 0);
        end else begin
            chk("first_rd", mem_rd_o, 1);
            chk("first_adr", mem_adr_o, base);
            chk("busy_on", busy_o, 1);
        end
        seen = done_o;
        for (int i = 1; i < lim && !seen; i++) begin
            @(negedge clk);
            if (i == inj) begin
                start_i = 1'b1; base_adr_i = base + 15'h10; word_cnt_i = 15'd2;
            end else start_i = 1'b0;
            seen = done_o;
        end
        start_i = 1'b0;
        chk("done_seen", seen, 1);
        chk("busy_in_done", busy_o, 0);
        @(negedge clk);
        chk("done_width", done_o, 0);
        @(negedge clk);
        chk("busy_cycles", n_busy - b0, int'(cnt) * (2 + 40 * C));
        chk("done_pulses", n_done - d0, 1);
        chk("reads", rd_adr.size() - r0, cnt);
        for (int i = 0; i < int'(cnt) && r0 + i < rd_adr.size(); i++)
            chk("rd_adr", rd_adr[r0 + i], (int'(base) + i) & 32'h7FFF);
        chk("frames", rx_q.size() - f0, 4 * int'(cnt));
        for (int k = 0; k < 4 * int'(cnt) && f0 + k < rx_q.size(); k++) begin
            a  = (int'(base) + k / 4) & 32'h7FFF;
            eb = 8'(mem[a] >> (8 * (k % 4)));
            chk("byte", rx_q[f0 + k], {23'd0, 1'b1, eb});
        end
        for (int k = 0; k < 4 * int'(cnt) && s0 + k < fs_q.size(); k++)
            if (k == 0) chk("first_start_lat", fs_q[s0] - c0, 2);
            else chk("frame_gap", fs_q[s0 + k] - fs_q[s0 + k - 1], (k % 4 == 0) ? 42 : 40);
        if (cnt == 0) chk("zero_tx_high", n_txlow - t0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mem[32'h0010] = 32'h12345678;
        mem[32'h4000] = 32'hDEADBEEF;
        mem[32'h4001] = 32'h00000000;
        mem[32'h4002] = 32'hFFFFFFFF;
        mem[32'h7FFF] = 32'h01020304;
        mem[32'h0000] = 32'hCAFEF00D;
        mem[32'h0020] = 32'hA5C30F81;
        mem[32'h0030] = 32'h5A3CF07E;
        mem[32'h0040] = 32'h0F1E2D3C;
        mem[32'h0041] = 32'h4B5A6978;
        #1 rst = 1'b0;
        #1 check_reset("rst_init");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_dump(15'h0010, 15'd1, -1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_reset("rst_idle");
        @(negedge clk);
        rst = 1'b1;
        run_dump(15'h0123, 15'd0, -1);
        run_dump(15'h4000, 15'd3, -1);
        run_dump(15'h7FFF, 15'd2, -1);
        run_dump(15'h0020, 15'd1, 20);
        run_dump(15'h0030, 15'd1, -1);
        @(negedge clk);
        base_adr_i = 15'h0040; word_cnt_i = 15'd2; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (25) @(negedge clk);
        #1 rst = 1'b0;
        #1 check_reset("rst_frame");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_dump(15'h0040, 15'd2, -1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
